dm_port_arbiter: RTL and testbench
==================================

// Module: dm_port_arbiter
// PURPOSE
//  Shares the single-port data memory (DM) between the RISC-V core's load/store port and a host port.
//  The host port is the test loader / signature reader that preloads DM and reads back the signature
//  region starting at word 0x40. The arbiter sits between both requesters and the DM macro.
//  Round-robin fairness, optional host burst lock with bounded length, read-response routing.
// PARAMETERS
//  ADDR_W     10  word-address width (DM depth up to 2**ADDR_W words)
//  DATA_W     32  data width; byte enables are DATA_W/8 bits
//  MAX_BURST  8   max consecutive locked host grants before a forced yield to a pending core request (>=1)
// PORTS
//  clk        in   1         clock, rising edge
//  rst        in   1         asynchronous, active-low reset
//  c_req      in   1         core request valid
//  c_we       in   1         core write (1) / read (0)
//  c_be       in   DATA_W/8  core byte enables (writes only)
//  c_addr     in   ADDR_W    core word address
//  c_wdata    in   DATA_W    core write data
//  c_gnt      out  1         core request accepted this cycle
//  c_rvalid   out  1         core read data valid (1 cycle after grant of a read)
//  c_rdata    out  DATA_W    core read data
//  h_req, h_we, h_be, h_addr, h_wdata, h_gnt, h_rvalid, h_rdata: host equivalents, same widths
//  h_lock     in   1         host requests to keep ownership on following cycles
//  m_en       out  1         DM access enable
//  m_we       out  DATA_W/8  DM byte write enables (0 on reads)
//  m_addr     out  ADDR_W    DM word address
//  m_wdata    out  DATA_W    DM write data
//  m_rdata    in   DATA_W    DM read data, valid the cycle after a read access
// BEHAVIOUR
//  Reset (rst=0): all outputs 0; state=IDLE; last_gnt=HOST (core wins the first tie); burst_cnt=0; rd_tag cleared.
//  Grant is combinational, same cycle as req: at most one of c_gnt/h_gnt is high; a gnt only accompanies its req.
//  m_* is a combinational mux of the granted requester; m_en=|gnt; m_we=be & {we} of the winner; no grant -> m_*=0.
//  A requester holds req/addr/data stable until gnt (request is not withdrawn on no-grant).
//  FSM states: IDLE (no grant last cycle), CORE, HOST, HOST_LOCK.
//   IDLE/CORE/HOST: only one req -> grant it; both -> grant the requester != last_gnt.
//   Host granted with h_lock=1 -> HOST_LOCK, burst_cnt=1.
//   HOST_LOCK: h_req&h_lock -> host granted ahead of core, burst_cnt++; if burst_cnt==MAX_BURST and c_req,
//    core is granted for one cycle (forced yield), burst_cnt=0, state CORE; then normal round-robin applies.
//   HOST_LOCK with h_lock=0 or h_req=0 -> behave as HOST (round-robin, last_gnt=HOST).
//   Next state = owner of this cycle's grant (CORE/HOST/HOST_LOCK), IDLE if none. last_gnt updates on every grant.
//  Reads: registered rd_tag = {valid, owner} on a granted read; next cycle the tagged owner's rvalid=1.
//   c_rdata = h_rdata = m_rdata (always driven); rvalid qualifies. Writes produce no rvalid.
//   Back-to-back reads from alternating owners each get exactly one rvalid, in grant order.
//  Latency: grant 0 cycles, read data 1 cycle after grant; throughput 1 access/cycle.
//  burst_cnt saturates at MAX_BURST; it clears whenever the host is not granted.
//  Reset mid-access: pending rvalid dropped, no DM write issued while rst=0.
// STRUCTURE
//  Package dm_arb_pkg: owner_e {OWN_CORE, OWN_HOST}, state_e {IDLE, CORE, HOST, HOST_LOCK},
//   rd_tag_t struct {logic vld; owner_e own}.
//  Sub-module rr_arb2: 2-way round-robin picker (req[1:0], last, prio_host, force_core -> gnt[1:0]).
//  Top holds FSM, burst counter, rd_tag register, output muxes.
// TESTING
//  1 Core-only: core read 0x40 with DM[0x40]=0xDEADBEEF -> c_gnt same cycle, c_rvalid=1 & c_rdata=0xDEADBEEF next cycle, h_rvalid=0.
//  2 Contention: c_req and h_req held high 6 cycles, no lock -> grants alternate C,H,C,H,C,H starting with core after reset.
//  3 Host burst: h_lock=1, h_req and c_req held high, MAX_BURST=8 -> host granted 8 cycles, core the 9th, then alternation.
//  4 Byte write: host write be=0b0011 addr 0x41 data 0x12345678 onto 0xFFFFFFFF -> DM[0x41]=0xFFFF5678; no rvalid.
//  5 Read routing: host read 0x40 then core read 0x42 on the next cycle -> h_rvalid in cycle 2, c_rvalid in cycle 3, one each.
//  6 Reset: assert rst=0 on the cycle after a granted read -> all outputs 0 immediately, no rvalid after release; first tie goes to core.

Source files
------------

// File: rtl/dm_arb_pkg.sv
// Shared types for the data-memory port arbiter: requester owner, arbiter FSM state,
// read-response tag and grant-vector encodings.
package dm_arb_pkg;

    typedef enum logic {
        OWN_CORE = 1'b0,
        OWN_HOST = 1'b1
    } owner_e;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CORE      = 2'd1,
        HOST      = 2'd2,
        HOST_LOCK = 2'd3
    } state_e;

    typedef struct packed {
        logic   vld;
        owner_e own;
    } rd_tag_t;

    // Grant vectors are one-hot: bit 0 = core, bit 1 = host.
    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_CORE = 2'b01;
    localparam logic [1:0] GNT_HOST = 2'b10;

    function automatic owner_e owner_of(input logic [1:0] gnt);
        if (gnt[1]) begin
            return OWN_HOST;
        end else begin
            return OWN_CORE;
        end
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker between the core (bit 0) and host (bit 1) requesters,
// with an override for a locked host burst and for the forced yield back to the core.
module rr_arb2
    import dm_arb_pkg::*;
(
    input  logic [1:0] i_req,
    input  owner_e     i_last,
    input  logic       i_prio_host,
    input  logic       i_force_core,
    output logic [1:0] o_gnt
);

    // Forced yield beats the host lock, which beats plain round-robin.
    always_comb begin
        o_gnt = GNT_NONE;
        if (i_force_core && i_req[0]) begin
            o_gnt = GNT_CORE;
        end else if (i_prio_host && i_req[1]) begin
            o_gnt = GNT_HOST;
        end else begin
            case (i_req)
                2'b01:   o_gnt = GNT_CORE;
                2'b10:   o_gnt = GNT_HOST;
                2'b11:   o_gnt = (i_last == OWN_HOST) ? GNT_CORE : GNT_HOST;
                default: o_gnt = GNT_NONE;
            endcase
        end
    end

endmodule

// File: rtl/dm_port_arbiter.sv
// Shares the single-port data memory between the core load/store port and the host
// loader port: same-cycle grant, bounded host burst lock, one-cycle read-response routing.
module dm_port_arbiter
    import dm_arb_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                c_req,
    input  logic                c_we,
    input  logic [DATA_W/8-1:0] c_be,
    input  logic [ADDR_W-1:0]   c_addr,
    input  logic [DATA_W-1:0]   c_wdata,
    output logic                c_gnt,
    output logic                c_rvalid,
    output logic [DATA_W-1:0]   c_rdata,
    input  logic                h_req,
    input  logic                h_we,
    input  logic [DATA_W/8-1:0] h_be,
    input  logic [ADDR_W-1:0]   h_addr,
    input  logic [DATA_W-1:0]   h_wdata,
    input  logic                h_lock,
    output logic                h_gnt,
    output logic                h_rvalid,
    output logic [DATA_W-1:0]   h_rdata,
    output logic                m_en,
    output logic [DATA_W/8-1:0] m_we,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    input  logic [DATA_W-1:0]   m_rdata
);

    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e           r_state;
    state_e           w_state_nxt;
    owner_e           r_last;
    owner_e           w_last_nxt;
    logic [CNT_W-1:0] r_burst_cnt;
    logic [CNT_W-1:0] w_burst_nxt;
    rd_tag_t          r_rd_tag;
    rd_tag_t          w_rd_tag_nxt;

    logic [1:0] w_req;
    logic [1:0] w_arb_gnt;
    logic [1:0] w_gnt;
    logic       w_lock_active;
    logic       w_force_core;
    logic       w_gnt_we;

    assign w_req         = {h_req, c_req};
    assign w_lock_active = (r_state == HOST_LOCK) && h_req && h_lock;
    assign w_force_core  = w_lock_active && (r_burst_cnt == CNT_MAX) && c_req;

    rr_arb2 u_rr_arb2 (
        .i_req        (w_req),
        .i_last       (r_last),
        .i_prio_host  (w_lock_active),
        .i_force_core (w_force_core),
        .o_gnt        (w_arb_gnt)
    );

    // Reset gates the grant so no DM access (and no write) can leave while rst is low.
    assign w_gnt    = rst ? w_arb_gnt : GNT_NONE;
    assign c_gnt    = w_gnt[0];
    assign h_gnt    = w_gnt[1];
    assign w_gnt_we = w_gnt[1] ? h_we : c_we;

    assign c_rvalid = r_rd_tag.vld && (r_rd_tag.own == OWN_CORE);
    assign h_rvalid = r_rd_tag.vld && (r_rd_tag.own == OWN_HOST);
    assign c_rdata  = rst ? m_rdata : {DATA_W{1'b0}};
    assign h_rdata  = rst ? m_rdata : {DATA_W{1'b0}};

    // DM request mux driven by whichever requester won this cycle.
    always_comb begin
        m_en    = 1'b0;
        m_we    = {BE_W{1'b0}};
        m_addr  = {ADDR_W{1'b0}};
        m_wdata = {DATA_W{1'b0}};
        case (w_gnt)
            GNT_CORE: begin
                m_en    = 1'b1;
                m_we    = c_be & {BE_W{c_we}};
                m_addr  = c_addr;
                m_wdata = c_wdata;
            end
            GNT_HOST: begin
                m_en    = 1'b1;
                m_we    = h_be & {BE_W{h_we}};
                m_addr  = h_addr;
                m_wdata = h_wdata;
            end
            default: begin
                m_en    = 1'b0;
                m_we    = {BE_W{1'b0}};
                m_addr  = {ADDR_W{1'b0}};
                m_wdata = {DATA_W{1'b0}};
            end
        endcase
    end

    // Next state follows this cycle's owner; burst count only survives consecutive locked host grants.
    always_comb begin
        w_state_nxt      = IDLE;
        w_last_nxt       = r_last;
        w_burst_nxt      = {CNT_W{1'b0}};
        w_rd_tag_nxt.vld = 1'b0;
        w_rd_tag_nxt.own = OWN_CORE;
        case (w_gnt)
            GNT_CORE: begin
                w_state_nxt = CORE;
                w_last_nxt  = OWN_CORE;
            end
            GNT_HOST: begin
                w_last_nxt = OWN_HOST;
                if (h_lock) begin
                    w_state_nxt = HOST_LOCK;
                    if (!w_lock_active) begin
                        w_burst_nxt = CNT_ONE;
                    end else if (r_burst_cnt == CNT_MAX) begin
                        w_burst_nxt = CNT_MAX;
                    end else begin
                        w_burst_nxt = r_burst_cnt + CNT_ONE;
                    end
                end else begin
                    w_state_nxt = HOST;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        if ((w_gnt != GNT_NONE) && !w_gnt_we) begin
            w_rd_tag_nxt.vld = 1'b1;
            w_rd_tag_nxt.own = owner_of(w_gnt);
        end else begin
            w_rd_tag_nxt.vld = 1'b0;
            w_rd_tag_nxt.own = OWN_CORE;
        end
    end

    // State, fairness history, burst counter and read tag registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_last       <= OWN_HOST;
            r_burst_cnt  <= {CNT_W{1'b0}};
            r_rd_tag.vld <= 1'b0;
            r_rd_tag.own <= OWN_CORE;
        end else begin
            r_state     <= w_state_nxt;
            r_last      <= w_last_nxt;
            r_burst_cnt <= w_burst_nxt;
            r_rd_tag    <= w_rd_tag_nxt;
        end
    end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed bench for dm_port_arbiter: vector table for single-cycle behaviour plus
// hand sequences for the host burst lock and mid-access reset.
module tb_dm_port_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int BW = 4;
    localparam int MB = 8;
    localparam int NV = 20;

    logic          clk = 1'b0;
    logic          rst;
    logic          c_req, c_we, h_req, h_we, h_lock;
    logic [BW-1:0] c_be, h_be;
    logic [AW-1:0] c_addr, h_addr;
    logic [DW-1:0] c_wdata, h_wdata;
    logic          c_gnt, c_rvalid, h_gnt, h_rvalid, m_en;
    logic [DW-1:0] c_rdata, h_rdata, m_wdata;
    logic [DW-1:0] m_rdata = 32'h0;
    logic [BW-1:0] m_we;
    logic [AW-1:0] m_addr;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic          c_req, c_we;
        logic [BW-1:0] c_be;
        logic [AW-1:0] c_addr;
        logic [DW-1:0] c_wdata;
        logic          h_req, h_we;
        logic [BW-1:0] h_be;
        logic [AW-1:0] h_addr;
        logic [DW-1:0] h_wdata;
        logic          h_lock;
        logic          e_cg, e_hg, e_crv, e_hrv;
        logic [DW-1:0] e_rdata;
    } vec_t;

    vec_t tv [NV];

    always #5 clk = ~clk;

    dm_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst),
        .c_req(c_req), .c_we(c_we), .c_be(c_be), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .h_req(h_req), .h_we(h_we), .h_be(h_be), .h_addr(h_addr), .h_wdata(h_wdata),
        .h_lock(h_lock), .h_gnt(h_gnt), .h_rvalid(h_rvalid), .h_rdata(h_rdata),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
    );

    // Behavioural single-port DM macro: byte-enable writes, registered read data.
    always @(posedge clk) begin
        if (m_en) begin
            if (m_we == 4'h0) begin
                m_rdata <= mem[m_addr];
            end else begin
                for (int b = 0; b < BW; b++) begin
                    if (m_we[b]) mem[m_addr][8*b +: 8] <= m_wdata[8*b +: 8];
                end
            end
        end
    end

    function automatic vec_t mkv(
        input logic cr, input logic cw, input logic [3:0] cb, input logic [9:0] ca, input logic [31:0] cd,
        input logic hr, input logic hw, input logic [3:0] hb, input logic [9:0] ha, input logic [31:0] hd,
        input logic lk, input logic ecg, input logic ehg, input logic ecrv, input logic ehrv, input logic [31:0] erd);
        vec_t v;
        v.c_req = cr; v.c_we = cw; v.c_be = cb; v.c_addr = ca; v.c_wdata = cd;
        v.h_req = hr; v.h_we = hw; v.h_be = hb; v.h_addr = ha; v.h_wdata = hd;
        v.h_lock = lk; v.e_cg = ecg; v.e_hg = ehg; v.e_crv = ecrv; v.e_hrv = ehrv; v.e_rdata = erd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        c_req = v.c_req; c_we = v.c_we; c_be = v.c_be; c_addr = v.c_addr; c_wdata = v.c_wdata;
        h_req = v.h_req; h_we = v.h_we; h_be = v.h_be; h_addr = v.h_addr; h_wdata = v.h_wdata;
        h_lock = v.h_lock;
    endtask

    task automatic check_vec(input string tag, input vec_t v);
        logic          e_en;
        logic [BW-1:0] e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd;
        e_en = v.e_cg | v.e_hg;
        e_we = v.e_cg ? (v.c_be & {BW{v.c_we}}) : v.e_hg ? (v.h_be & {BW{v.h_we}}) : 4'h0;
        e_addr = v.e_cg ? v.c_addr : v.e_hg ? v.h_addr : 10'h0;
        e_wd = v.e_cg ? v.c_wdata : v.e_hg ? v.h_wdata : 32'h0;
        chk({tag, " c_gnt"}, {31'h0, c_gnt}, {31'h0, v.e_cg});
        chk({tag, " h_gnt"}, {31'h0, h_gnt}, {31'h0, v.e_hg});
        chk({tag, " c_rvalid"}, {31'h0, c_rvalid}, {31'h0, v.e_crv});
        chk({tag, " h_rvalid"}, {31'h0, h_rvalid}, {31'h0, v.e_hrv});
        chk({tag, " m_en"}, {31'h0, m_en}, {31'h0, e_en});
        chk({tag, " m_we"}, {28'h0, m_we}, {28'h0, e_we});
        chk({tag, " m_addr"}, {22'h0, m_addr}, {22'h0, e_addr});
        chk({tag, " m_wdata"}, m_wdata, e_wd);
        if (v.e_crv) chk({tag, " c_rdata"}, c_rdata, v.e_rdata);
        if (v.e_hrv) chk({tag, " h_rdata"}, h_rdata, v.e_rdata);
    endtask

    initial begin
        vec_t idle;
        idle = mkv(1'b0, 1'b0, 4'h0, 10'h0, 32'h0, 1'b0, 1'b0, 4'h0, 10'h0, 32'h0, 1'b0,
                   1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

        // Contention: core wins first tie after reset, then strict alternation.
        for (int i = 0; i < 6; i++) begin
            tv[i] = mkv(1'b1, 1'b1, 4'hF, 10'h010, 32'h11111111, 1'b1, 1'b1, 4'hF, 10'h040, 32'hDEADBEEF,
                        1'b0, (i % 2 == 0), (i % 2 == 1), 1'b0, 1'b0, 32'h0);
        end
        tv[6]  = mkv(1'b0, 1'b0, 4'h0, 10'h000, 32'h0, 1'b1, 1'b1, 4'hF, 10'h041, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        tv[7]  = mkv(1'b0, 1'b0, 4'h0, 10'h000, 32'h0, 1'b1, 1'b1, 4'hF, 10'h042, 32'hA5A5A5A5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        tv[8]  = mkv(1'b0, 1'b0, 4'h0, 10'h000, 32'h0, 1'b1, 1'b1, 4'h3, 10'h041, 32'h12345678, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        tv[9]  = mkv(1'b1, 1'b0, 4'h0, 10'h040, 32'h0, 1'b0, 1'b0, 4'h0, 10'h000, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        tv[10] = mkv(1'b0, 1'b0, 4'h0, 10'h000, 32'h0, 1'b0, 1'b0, 4'h0, 10'h000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF);
        tv[11] = mkv(1'b0, 1'b0, 4'h0, 10'h000, 32'h0, 1'b1, 1'b0, 4'h0, 10'h041, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        tv[12] = mkv(1'b1, 1'b0, 4'h0, 10'h042, 32'h0, 1'b0, 1'b0, 4'h0, 10'h000, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF5678);
        tv[13] = mkv(1'b0, 1'b0, 4'h0, 10'h000, 32'h0, 1'b0, 1'b0, 4'h0, 10'h000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hA5A5A5A5);
        tv[14] = mkv(1'b0, 1'b0, 4'h0, 10'h000, 32'h0, 1'b1, 1'b0, 4'h0, 10'h040, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        tv[15] = mkv(1'b1, 1'b0, 4'h0, 10'h042, 32'h0, 1'b0, 1'b0, 4'h0, 10'h000, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF);
        tv[16] = mkv(1'b0, 1'b0, 4'h0, 10'h000, 32'h0, 1'b0, 1'b0, 4'h0, 10'h000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hA5A5A5A5);
        tv[17] = mkv(1'b1, 1'b0, 4'h0, 10'h041, 32'h0, 1'b1, 1'b0, 4'h0, 10'h040, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        tv[18] = mkv(1'b1, 1'b0, 4'h0, 10'h041, 32'h0, 1'b0, 1'b0, 4'h0, 10'h000, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF);
        tv[19] = mkv(1'b0, 1'b0, 4'h0, 10'h000, 32'h0, 1'b0, 1'b0, 4'h0, 10'h000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFF5678);

        rst = 1'b0;
        drive(idle);
        #1;
        check_vec("reset", idle);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(tv[i]);
            #1;
            check_vec($sformatf("row%0d", i), tv[i]);
        end

        // Host burst lock: 8 locked host grants, forced core yield, then round-robin.
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            drive(mkv(1'b1, 1'b1, 4'hF, 10'h060, 32'h0C0C0C0C, 1'b1, 1'b1, 4'hF, 10'h050, 32'h50505050,
                      (i < 9), 1'b0, 1'b0, 1'b0, 1'b0, 32'h0));
            #1;
            chk($sformatf("burst%0d c_gnt", i), {31'h0, c_gnt}, {31'h0, (i == 8 || i == 10)});
            chk($sformatf("burst%0d h_gnt", i), {31'h0, h_gnt}, {31'h0, !(i == 8 || i == 10)});
        end

        // Reset on the cycle after a granted host read.
        @(negedge clk);
        drive(idle);
        @(negedge clk);
        drive(mkv(1'b0, 1'b0, 4'h0, 10'h000, 32'h0, 1'b1, 1'b0, 4'h0, 10'h041, 32'h0, 1'b0,
                  1'b0, 1'b1, 1'b0, 1'b0, 32'h0));
        #1;
        chk("rst_pre h_gnt", {31'h0, h_gnt}, 32'h1);
        @(negedge clk);
        drive(mkv(1'b1, 1'b1, 4'hF, 10'h041, 32'h0, 1'b1, 1'b1, 4'hF, 10'h041, 32'h0, 1'b0,
                  1'b0, 1'b0, 1'b0, 1'b0, 32'h0));
        rst = 1'b0;
        #1;
        check_vec("rst_mid", idle);
        chk("rst_mid c_rdata", c_rdata, 32'h0);
        chk("rst_mid h_rdata", h_rdata, 32'h0);
        @(negedge clk);
        #1;
        check_vec("rst_hold", idle);
        @(negedge clk);
        rst = 1'b1;
        drive(idle);
        #1;
        check_vec("rst_rel", idle);
        @(negedge clk);
        drive(mkv(1'b1, 1'b0, 4'h0, 10'h041, 32'h0, 1'b1, 1'b0, 4'h0, 10'h042, 32'h0, 1'b0,
                  1'b1, 1'b0, 1'b0, 1'b0, 32'h0));
        #1;
        chk("rst_tie c_gnt", {31'h0, c_gnt}, 32'h1);
        chk("rst_tie h_gnt", {31'h0, h_gnt}, 32'h0);
        @(negedge clk);
        drive(idle);
        #1;
        chk("rst_rd c_rvalid", {31'h0, c_rvalid}, 32'h1);
        chk("rst_rd h_rvalid", {31'h0, h_rvalid}, 32'h0);
        chk("rst_rd c_rdata", c_rdata, 32'hFFFF5678);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
